// File: rtl/conv_window_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_ctrl_if
// Purpose  : Pixel-in / result-out handshake bundle for conv_window_ctrl.
//            Producer side (master) drives pixels and accepts results.
//            The window controller (slave) accepts pixels and offers results.
// Signals  : in_valid/in_ready/in_data   - pixel stream, all channels packed
//            out_valid/out_ready/out_data - registered layer result
// Revision : 1.0 - initial release
// ============================================================================
interface conv_window_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CIN   = 3,
  parameter int ZW    = 22
);
  logic                 in_valid;
  logic                 in_ready;
  logic [CIN*WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [ZW-1:0]        out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/conv_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_ctrl
// Purpose  : Streams a raster frame of CIN-channel pixels, keeps the last F
//            rows in a line buffer plus an F x F shift window, exposes the
//            window to an external combinational layer and registers its
//            result whenever the window is fully inside the frame (stride 1,
//            no padding).
// Ports    : clk, rst_n    - clock, asynchronous active-low reset
//            start         - one-cycle pulse starting a frame (IDLE only)
//            bus (slave)   - pixel input / result output handshakes
//            win           - current window, index c*F*F + ky*F + kx
//            res_z         - combinational layer result for win
//            busy, done    - frame in progress / end-of-frame pulse
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_ctrl #(
  parameter int WIDTH = 8,
  parameter int F     = 5,
  parameter int CIN   = 3,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int ZW    = 22
) (
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  start,
  conv_window_ctrl_if.slave    bus,
  output logic [WIDTH-1:0]     win [CIN*F*F],
  input  wire  [ZW-1:0]        res_z,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] c_col_last  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] c_row_last  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] c_col_first = CW'(F - 1);
  localparam logic [RW-1:0] c_row_first = RW'(F - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t            r_state;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  // Window registered on the previous accept is complete and awaits capture.
  logic              r_pend;
  // Previous F-1 rows; index 0 is the oldest row, F-2 the row just above.
  logic [CIN*WIDTH-1:0] r_lb [F-1][IMG_W];

  logic w_out_free;
  logic w_accept;
  logic w_pos_valid;
  logic w_load;
  logic w_last_pix;

  assign w_out_free   = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (r_state == STREAM) && w_out_free;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_pos_valid  = (r_row >= c_row_first) && (r_col >= c_col_first);
  // A pending window is captured as soon as the output register is free.
  // While it is not free in_ready is low, so win cannot move underneath it.
  assign w_load       = r_pend && w_out_free;
  assign w_last_pix   = (r_row == c_row_last) && (r_col == c_col_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_row         <= '0;
      r_col         <= '0;
      r_pend        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;

      if (w_load) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= res_z;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (w_accept) begin
        r_pend <= w_pos_valid;
      end else if (w_load) begin
        r_pend <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= STREAM;
            busy    <= 1'b1;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        STREAM: begin
          if (w_accept) begin
            if (r_col == c_col_last) begin
              r_col <= '0;
              r_row <= w_last_pix ? '0 : r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
            if (w_last_pix) begin
              r_state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // The final pixel is always a valid position, so this fires on the
          // handshake of the last result.
          if (!r_pend && w_out_free) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Datapath storage is never reset: a window is only flagged valid once
  // every row and column it covers has been rewritten in the current frame.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int c = 0; c < CIN; c++) begin
        for (int ky = 0; ky < F; ky++) begin
          for (int kx = 0; kx < F - 1; kx++) begin
            win[c*F*F + ky*F + kx] <= win[c*F*F + ky*F + kx + 1];
          end
          if (ky == F - 1) begin
            win[c*F*F + ky*F + F - 1] <= bus.in_data[c*WIDTH +: WIDTH];
          end else begin
            win[c*F*F + ky*F + F - 1] <= r_lb[ky][r_col][c*WIDTH +: WIDTH];
          end
        end
      end
      for (int ky = 0; ky < F - 2; ky++) begin
        r_lb[ky][r_col] <= r_lb[ky+1][r_col];
      end
      r_lb[F-2][r_col] <= bus.in_data;
    end
  end

endmodule
`default_nettype wire
